therm_dac_drv: RTL and testbench
================================

// Module: therm_dac_drv
// PURPOSE
//  Binary-to-thermometer decoder for the 15-element unary DAC: the inverse of the ADC's thermometer encoder.
//  Accepts 4-bit codes over a valid/ready handshake and buffers one code.
//  Drives 15 element-enable lines with data-weighted-averaging (DWA) rotation to spread element mismatch.
//  Sits between the digital loop/test source and the analog unary DAC array.
// PARAMETERS
//  NBITS  4   binary code width
//  NELEM  15  unary elements (2**NBITS-1); code k turns on k elements, k=0..15
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  din        in   NBITS  binary code
//  din_valid  in   1      din is valid this cycle
//  din_ready  out  1      block can accept din this cycle
//  hold       in   1      freeze DAC outputs; buffered code waits
//  dwa_en     in   1      1 = rotate the element pointer; 0 = plain thermometer from element 0
//  Y          out  NELEM  element enables, registered
//  upd        out  1      1-cycle pulse: Y was updated on this edge
//  ptr        out  NBITS  current DWA start pointer (debug), range 0..NELEM-1
// BEHAVIOUR
//  Reset (rst=0, async): buf_full=0, Y=0, ptr=0, upd=0. din_ready=1 once rst is released.
//  Stage 1 is a 1-entry buffer (buf, buf_full).
//    din_ready = ~buf_full | ~hold.
//    A code is accepted on an edge where din_valid & din_ready.
//  Stage 2 is an apply. It occurs on an edge where buf_full & ~hold:
//    Y <= rot(buf, ptr); ptr <= ptr_n; upd <= 1.
//    On every other edge: upd <= 0, and Y and ptr hold.
//  Simultaneous apply and accept on the same edge is legal.
//    buf takes the new code; buf_full stays 1.
//  Next state: buf_full_n = accept | (buf_full & ~apply).
//  Latency: code accepted at edge N appears on Y at edge N+1 if hold=0 at N+1.
//    Sustained throughput is 1 code/cycle.
//  hold=1 with buf_full=1:
//    din_ready=0; din/din_valid must be held by the source; Y and ptr are frozen.
//  hold=1 with buf_full=0: one code may still be accepted; it fills the buffer and is not applied.
//  rot(k,p): element i is on iff ((i - p) mod NELEM) < k, for i = 0..NELEM-1.
//    k=0 gives all off; k=15 gives all on.
//  ptr_n, when dwa_en=1: (ptr + k) mod NELEM.
//    Computed in NBITS+1 bits; subtract NELEM if the sum >= NELEM.
//    k=15 leaves ptr unchanged.
//  ptr_n, when dwa_en=0: Y=rot(k,0) and ptr_n=0.
//    dwa_en is sampled only at apply; toggling it mid-stream takes effect at the next apply.
//  popcount(Y) always equals the last applied code; no other Y pattern is ever driven.
//  Y changes only on apply edges, with no intermediate codes.
//  Reset mid-operation drops any buffered code; Y=0 immediately (async).
// STRUCTURE
//  Shared package adc_pkg holds:
//    constants ADC_NBITS=4 and ADC_NELEM=15;
//    function mod_add(a,b) returning (a+b) mod ADC_NELEM.
//  The same constants serve the ADC thermometer encoder.
//  Sub-module therm_rot (combinational): inputs k and p, output en[NELEM-1:0] = rot(k,p).
//  Top level holds the buffer, the handshake, the pointer register and the output registers.
// TESTING
//  1 Reset: rst=0 while din_valid=1, din=9 -> Y=0, ptr=0, upd=0; after release, din_ready=1.
//  2 dwa_en=0: codes 3,15,0 back-to-back.
//    -> Y = 0x0007, 0x7FFF, 0x0000 on consecutive edges; ptr stays 0; upd=1 each cycle.
//  3 dwa_en=1 from ptr=0: codes 5,7,6.
//    -> Y=0x001F then ptr=5; Y=0x0FE0 then ptr=12; Y=0x7007 then ptr=3 (wrap).
//  4 dwa_en=1, ptr=3, code 15 -> Y=0x7FFF and ptr stays 3.
//    code 0 -> Y=0x0000, upd=1, ptr stays 3.
//  5 hold=1 and two codes offered (4 then 2):
//    -> first accepted; din_ready=0; second stalls; Y unchanged.
//    On hold=0, code 4 applies, then code 2 on the next edge.
//  6 Assert rst mid-stream with buf_full=1 -> buffer dropped, Y=0 asynchronously, no upd after release.
//    Random soak with scoreboard: popcount(Y)==code, ptr == running sum mod 15.

Source files
------------

// File: rtl/therm_dac_drv_pkg.sv
// adc_pkg: constants, types and modular pointer arithmetic shared by the
// thermometer DAC driver and the ADC thermometer encoder.
package adc_pkg;

    localparam int ADC_NBITS = 4;
    localparam int ADC_NELEM = 15;

    typedef logic [ADC_NBITS-1:0] code_t;
    typedef logic [ADC_NELEM-1:0] therm_t;

    // (a + b) mod ADC_NELEM, valid for a < ADC_NELEM and b <= ADC_NELEM
    function automatic code_t mod_add(input code_t a, input code_t b);
        logic [ADC_NBITS:0] s;
        logic [ADC_NBITS:0] r;
        s = {1'b0, a} + {1'b0, b};
        r = (s >= (ADC_NBITS+1)'(ADC_NELEM)) ? s - (ADC_NBITS+1)'(ADC_NELEM) : s;
        return r[ADC_NBITS-1:0];
    endfunction

endpackage

// File: rtl/therm_dac_drv_rot.sv
// therm_rot: rotated thermometer decode, element i on iff ((i - p) mod NELEM) < k.
module therm_rot
    import adc_pkg::*;
(
    input  code_t  k,
    input  code_t  p,
    output therm_t en
);

    for (genvar i = 0; i < ADC_NELEM; i++) begin : g_el
        code_t d;
        // distance from the start pointer, wrapped into 0..NELEM-1
        assign d = (ADC_NBITS'(i) >= p) ? ADC_NBITS'(i) - p
                                        : ADC_NBITS'(i) + ADC_NBITS'(ADC_NELEM) - p;
        assign en[i] = d < k;
    end

endmodule

// File: rtl/therm_dac_drv.sv
// therm_dac_drv: 1-entry buffered binary-to-thermometer driver for the unary
// DAC, with data-weighted-averaging rotation of the element start pointer.
module therm_dac_drv
    import adc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADC_NBITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 hold,
    input  logic                 dwa_en,
    output logic [ADC_NELEM-1:0] Y,
    output logic                 upd,
    output logic [ADC_NBITS-1:0] ptr
);

    logic   buf_full_q, buf_full_d;
    code_t  buf_q, buf_d;
    therm_t y_q, y_d;
    code_t  ptr_q, ptr_d;
    logic   upd_q, upd_d;
    logic   accept, apply;
    code_t  rot_p;
    therm_t rot_en;

    assign rot_p = dwa_en ? ptr_q : '0;

    therm_rot u_rot (
        .k  (buf_q),
        .p  (rot_p),
        .en (rot_en)
    );

    always_comb begin
        din_ready  = ~buf_full_q | ~hold;
        accept     = din_valid & din_ready;
        apply      = buf_full_q & ~hold;
        buf_full_d = accept | (buf_full_q & ~apply);
        buf_d      = accept ? din : buf_q;
        y_d        = apply ? rot_en : y_q;
        ptr_d      = apply ? (dwa_en ? mod_add(ptr_q, buf_q) : '0) : ptr_q;
        upd_d      = apply;
    end

    // active-low asynchronous reset drops any buffered code
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            y_q        <= '0;
            ptr_q      <= '0;
            upd_q      <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            y_q        <= y_d;
            ptr_q      <= ptr_d;
            upd_q      <= upd_d;
        end
    end

    assign Y   = y_q;
    assign ptr = ptr_q;
    assign upd = upd_q;

endmodule

// File: tb/tb_therm_dac_drv.sv
// tb_therm_dac_drv: directed vectors with hand-computed values plus a
// reference-model soak for the DWA thermometer DAC driver.
module tb_therm_dac_drv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        hold = 1'b0;
    logic        dwa_en = 1'b0;
    logic [14:0] Y;
    logic        upd;
    logic [3:0]  ptr;

    int errs = 0;
    int checks = 0;

    logic        m_full = 1'b0;
    int          m_buf = 0;
    int          m_ptr = 0;
    int          m_last = 0;
    logic [14:0] m_y = '0;
    logic        m_upd = 1'b0;

    therm_dac_drv dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .hold      (hold),
        .dwa_en    (dwa_en),
        .Y         (Y),
        .upd       (upd),
        .ptr       (ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] rotm(input int k, input int p);
        logic [14:0] r;
        for (int i = 0; i < 15; i++) r[i] = ((i - p + 15) % 15) < k;
        return r;
    endfunction

    task automatic model_reset();
        m_full = 1'b0; m_buf = 0; m_ptr = 0; m_last = 0; m_y = '0; m_upd = 1'b0;
    endtask

    // drive one cycle of inputs, then check outputs 1 time unit after the edge
    task automatic step(input logic v, input logic [3:0] d, input logic h, input logic e);
        logic rdy, acc, app;
        din_valid = v; din = d; hold = h; dwa_en = e;
        #1;
        rdy = !m_full || !h;
        chk("din_ready", 32'(din_ready), 32'(rdy));
        acc = v && rdy;
        app = m_full && !h;
        @(posedge clk); #1;
        if (app) begin
            m_y    = rotm(m_buf, e ? m_ptr : 0);
            m_ptr  = e ? (m_ptr + m_buf) % 15 : 0;
            m_last = m_buf;
        end
        m_upd = app;
        if (acc) m_buf = int'(d);
        m_full = acc || (m_full && !app);
        chk("model_y", 32'(Y), 32'(m_y));
        chk("model_ptr", 32'(ptr), 32'(m_ptr));
        chk("model_upd", 32'(upd), 32'(m_upd));
        chk("popcount", 32'($countones(Y)), 32'(m_last));
    endtask

    initial begin
        logic       cv, ch, ce, will_acc;
        logic [3:0] cd;
        // 1: reset with a valid code presented
        din_valid = 1'b1; din = 4'd9;
        #12;
        chk("rst_y", 32'(Y), 0);
        chk("rst_ptr", 32'(ptr), 0);
        chk("rst_upd", 32'(upd), 0);
        din_valid = 1'b0;
        @(negedge clk); rst = 1'b1; #1;
        chk("rst_ready", 32'(din_ready), 1);
        // 2: plain thermometer
        step(1, 4'd3, 0, 0);
        chk("t2_y_idle", 32'(Y), 0);
        step(1, 4'd15, 0, 0);
        chk("t2_y3", 32'(Y), 'h0007); chk("t2_upd3", 32'(upd), 1); chk("t2_ptr3", 32'(ptr), 0);
        step(1, 4'd0, 0, 0);
        chk("t2_y15", 32'(Y), 'h7FFF); chk("t2_upd15", 32'(upd), 1); chk("t2_ptr15", 32'(ptr), 0);
        step(0, 4'd0, 0, 0);
        chk("t2_y0", 32'(Y), 'h0000); chk("t2_upd0", 32'(upd), 1); chk("t2_ptr0", 32'(ptr), 0);
        // 3: DWA rotation with wrap
        step(1, 4'd5, 0, 1);
        step(1, 4'd7, 0, 1);
        chk("t3_y5", 32'(Y), 'h001F); chk("t3_ptr5", 32'(ptr), 5);
        step(1, 4'd6, 0, 1);
        chk("t3_y7", 32'(Y), 'h0FE0); chk("t3_ptr12", 32'(ptr), 12);
        step(0, 4'd0, 0, 1);
        chk("t3_y6", 32'(Y), 'h7007); chk("t3_ptr3", 32'(ptr), 3);
        // 4: full-scale and zero codes leave the pointer in place
        step(1, 4'd15, 0, 1);
        step(1, 4'd0, 0, 1);
        chk("t4_y15", 32'(Y), 'h7FFF); chk("t4_ptr15", 32'(ptr), 3);
        step(0, 4'd0, 0, 1);
        chk("t4_y0", 32'(Y), 'h0000); chk("t4_upd0", 32'(upd), 1); chk("t4_ptr0", 32'(ptr), 3);
        // 5: hold fills the buffer, then stalls the second code
        step(1, 4'd4, 1, 1);
        chk("t5_acc_y", 32'(Y), 0); chk("t5_acc_upd", 32'(upd), 0);
        chk("t5_ready_low", 32'(din_ready), 0);
        step(1, 4'd2, 1, 1);
        chk("t5_stall_y", 32'(Y), 0); chk("t5_stall_ptr", 32'(ptr), 3);
        step(1, 4'd2, 0, 1);
        chk("t5_y4", 32'(Y), 'h0078); chk("t5_ptr4", 32'(ptr), 7); chk("t5_upd4", 32'(upd), 1);
        step(0, 4'd0, 0, 1);
        chk("t5_y2", 32'(Y), 'h0180); chk("t5_ptr2", 32'(ptr), 9);
        // 6: asynchronous reset with a buffered code
        step(1, 4'd5, 1, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_y_async", 32'(Y), 0); chk("t6_ptr_async", 32'(ptr), 0); chk("t6_upd_async", 32'(upd), 0);
        model_reset();
        din_valid = 1'b0; hold = 1'b0;
        #2 rst = 1'b1;
        step(0, 4'd0, 0, 1);
        chk("t6_no_upd1", 32'(upd), 0); chk("t6_y1", 32'(Y), 0);
        step(0, 4'd0, 0, 1);
        chk("t6_no_upd2", 32'(upd), 0);
        // soak: source holds din/din_valid until accepted
        cv = 1'b0; cd = '0; ce = 1'b1;
        for (int n = 0; n < 400; n++) begin
            ch = ($urandom_range(3) == 0);
            if (n % 16 == 0) ce = ($urandom_range(3) != 0);
            will_acc = cv && (!m_full || !ch);
            step(cv, cd, ch, ce);
            if (will_acc || !cv) begin
                cv = ($urandom_range(9) < 7);
                cd = 4'($urandom_range(15));
            end
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
